// File: rtl/data_mem_pkg.sv
// Shared types for the data memory controller: controller FSM states and store-buffer defaults.
package data_mem_pkg;

    localparam int SB_DEPTH_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        LOAD  = 2'd2,
        LDONE = 2'd3
    } mem_state_t;

    // States in which a request is presented to the external memory.
    function automatic logic mem_busy(input mem_state_t s);
        return (s == DRAIN) || (s == LOAD);
    endfunction

endpackage

// File: rtl/store_fifo.sv
// Circular store buffer: word address/data pairs, wrap-around pointers, occupancy count.
// With DATA_MEM_CTRL_FWD_EN defined it also searches for the youngest entry matching a load.
module store_fifo
    import data_mem_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = SB_DEPTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_addr,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_addr,
    output logic [WIDTH-1:0] head_data,
`ifdef DATA_MEM_CTRL_FWD_EN
    input  logic [WIDTH-1:0] lookup_addr,
    output logic             hit,
    output logic [WIDTH-1:0] hit_data,
`endif
    output logic             empty,
    output logic             full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] addr_mem [DEPTH];
    logic [WIDTH-1:0] data_mem [DEPTH];
    logic [PW-1:0]    head_reg;
    logic [PW-1:0]    tail_reg;
    logic [CW-1:0]    count_reg;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CW'(DEPTH));
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (push_ok) begin
                tail_reg <= tail_reg + 1'b1;
            end
            if (pop_ok) begin
                head_reg <= head_reg + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Entry contents need no reset: the count alone decides what is live.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            addr_mem[tail_reg] <= push_addr;
            data_mem[tail_reg] <= push_data;
        end
    end

    assign head_addr = addr_mem[head_reg];
    assign head_data = data_mem[head_reg];

`ifdef DATA_MEM_CTRL_FWD_EN
    logic [DEPTH-1:0] entry_valid;
    logic [PW-1:0]    scan_idx;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_valid
            logic [PW-1:0] age;
            assign age             = PW'(gi) - head_reg;
            assign entry_valid[gi] = ({1'b0, age} < count_reg);
        end
    endgenerate

    // Scan oldest to youngest so the last hit seen is the youngest store.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        scan_idx = head_reg;
        for (int i = 0; i < DEPTH; i++) begin
            scan_idx = head_reg + PW'(i);
            if (entry_valid[scan_idx] && (addr_mem[scan_idx] == lookup_addr)) begin
                hit      = 1'b1;
                hit_data = data_mem[scan_idx];
            end
        end
    end
`endif

endmodule

// File: rtl/data_mem_ctrl.sv
// Data memory controller: zero-latency stores through a store buffer, loads via a miss FSM.
// Define DATA_MEM_CTRL_FWD_EN to forward buffered stores to matching loads.
module data_mem_ctrl
    import data_mem_pkg::*;
#(
    parameter int MIPS_SIZE = 32,
    parameter int SB_DEPTH  = SB_DEPTH_DEFAULT
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [MIPS_SIZE-1:0] ALUResult,
    input  logic [MIPS_SIZE-1:0] WriteData,
    input  logic                 MemWrite,
    input  logic                 MemRead,
    output logic [MIPS_SIZE-1:0] ReadData,
    output logic                 Stall,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [MIPS_SIZE-1:0] mem_addr,
    output logic [MIPS_SIZE-1:0] mem_wdata,
    input  logic                 mem_ack,
    input  logic [MIPS_SIZE-1:0] mem_rdata,
    output logic                 sb_empty
);

    localparam logic [MIPS_SIZE-1:0] ALIGN_MASK = ~MIPS_SIZE'(3);

    mem_state_t           state_reg;
    mem_state_t           state_next;
    logic [MIPS_SIZE-1:0] rdata_reg;
    logic [MIPS_SIZE-1:0] word_addr;
    logic [MIPS_SIZE-1:0] head_addr;
    logic [MIPS_SIZE-1:0] head_data;
    logic [MIPS_SIZE-1:0] rdata_int;
    logic                 load_req;
    logic                 load_go;
    logic                 push;
    logic                 pop;
    logic                 fifo_empty;
    logic                 fifo_full;
    logic                 stall_int;

    assign word_addr = ALUResult & ALIGN_MASK;
    assign load_req  = MemRead & ~MemWrite;
    assign push      = MemWrite & ~fifo_full;
    assign sb_empty  = fifo_empty;

`ifdef DATA_MEM_CTRL_FWD_EN
    logic                 fwd_hit;
    logic [MIPS_SIZE-1:0] fwd_data;

    assign load_go = load_req & ~fwd_hit;
`else
    // Without forwarding a load may only read memory once every older store has landed.
    assign load_go = load_req & fifo_empty;
`endif

    store_fifo #(
        .WIDTH (MIPS_SIZE),
        .DEPTH (SB_DEPTH)
    ) u_store_fifo (
        .clk         (CLK),
        .rst_n       (RST),
        .push        (push),
        .push_addr   (word_addr),
        .push_data   (WriteData),
        .pop         (pop),
        .head_addr   (head_addr),
        .head_data   (head_data),
`ifdef DATA_MEM_CTRL_FWD_EN
        .lookup_addr (word_addr),
        .hit         (fwd_hit),
        .hit_data    (fwd_data),
`endif
        .empty       (fifo_empty),
        .full        (fifo_full)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rdata_reg <= '0;
        end else if ((state_reg == LOAD) && mem_ack) begin
            rdata_reg <= mem_rdata;
        end
    end

    // A store pushed while idle counts as pending so its write starts on the next cycle.
    always_comb begin
        state_next = state_reg;
        pop        = 1'b0;
        mem_req    = mem_busy(state_reg);
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (state_reg)
            IDLE: begin
                if (load_go) begin
                    state_next = LOAD;
                end else if (!fifo_empty || push) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                mem_we    = 1'b1;
                mem_addr  = head_addr;
                mem_wdata = head_data;
                if (mem_ack) begin
                    pop        = 1'b1;
                    state_next = IDLE;
                end
            end
            LOAD: begin
                mem_addr = word_addr;
                if (mem_ack) begin
                    state_next = LDONE;
                end
            end
            LDONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        stall_int = 1'b0;
        rdata_int = '0;
        if (MemWrite) begin
            stall_int = fifo_full;
        end else if (load_req) begin
            if (state_reg == LDONE) begin
                rdata_int = rdata_reg;
`ifdef DATA_MEM_CTRL_FWD_EN
            end else if (fwd_hit) begin
                rdata_int = fwd_data;
`endif
            end else begin
                stall_int = 1'b1;
            end
        end
    end

    // Reset must silence the core-facing outputs even while the core still presents a request.
    assign Stall    = stall_int & RST;
    assign ReadData = RST ? rdata_int : '0;

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 SHALL have parameter MIPS_SIZE, default 32: data and address width.
REQ-002 SHALL have parameter SB_DEPTH, default 4: store-buffer entries, a power of 2 and at least 2.
REQ-003 SHALL have port CLK  input  1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port RST  input  1: reset, asynchronous assert, active-low.
REQ-005 SHALL have port ALUResult  input  MIPS_SIZE: byte address of the load or store, taken from the datapath.
REQ-006 SHALL have port WriteData  input  MIPS_SIZE: store data.
REQ-007 SHALL have port MemWrite  input  1: store request.
REQ-008 SHALL have port MemRead  input  1: load request.
REQ-009 SHALL have port ReadData  output  MIPS_SIZE: load data returned to the datapath.
REQ-010 SHALL have port Stall  output  1: the core holds PC and all inputs stable while this is 1.
REQ-011 SHALL have port mem_req  output  1: request to the external memory.
REQ-012 SHALL have port mem_we  output  1: 1 = write, 0 = read.
REQ-013 SHALL have port mem_addr  output  MIPS_SIZE: word-aligned address; bits [1:0] are always 0.
REQ-014 SHALL have port mem_wdata  output  MIPS_SIZE: write data.
REQ-015 SHALL have port mem_ack  input  1: the memory completes the request on a rising edge where mem_req=1 and mem_ack=1.
REQ-016 SHALL have port mem_rdata  input  MIPS_SIZE: read data, valid when mem_ack=1.
REQ-017 SHALL have port sb_empty  output  1: store buffer holds 0 entries.

Function
REQ-018 SHALL treat all accesses as word accesses and ignore ALUResult[1:0].
REQ-019 SHALL give MemWrite priority when MemWrite=1 and MemRead=1 in the same cycle, and ignore the read.
REQ-020 SHALL accept a store into the buffer tail on a rising edge with MemWrite=1 and Stall=0; store latency is 0 cycles to the core.
REQ-021 SHALL assert Stall=1 combinationally for a store while the entry count equals SB_DEPTH; no push-through-pop in the same cycle.
REQ-022 SHALL, for a load whose address matches any buffer entry, drive ReadData combinationally from the youngest matching entry with Stall=0.
REQ-023 SHALL, for a load with no buffer match (a miss), assert Stall=1 until the LDONE state.
REQ-024 SHALL implement FSM states IDLE, DRAIN, LOAD and LDONE.
REQ-025 SHALL, in IDLE, go to LOAD on a pending load miss, else go to DRAIN if the buffer is non-empty, else stay in IDLE; a load miss has priority over draining.
REQ-026 SHALL, in DRAIN, drive mem_req=1, mem_we=1 and the head entry's address and data; on ack, pop the head and return to IDLE.
REQ-027 SHALL never abort a DRAIN that has started; a load miss arriving during DRAIN waits for IDLE.
REQ-028 SHALL, in LOAD, drive mem_req=1, mem_we=0 and mem_addr = {ALUResult[MIPS_SIZE-1:2], 2'b00}; on ack, register mem_rdata and go to LDONE.
REQ-029 SHALL, in LDONE, drive Stall=0 and ReadData = the registered data for exactly 1 cycle, then go to IDLE.
REQ-030 SHALL hold mem_addr, mem_wdata and mem_we stable while mem_req=1, and ignore mem_ack when mem_req=0.
REQ-031 SHALL drive ReadData=0 when no load data is being returned.
REQ-032 SHALL use wrap-around head and tail pointers modulo SB_DEPTH and a count of width $clog2(SB_DEPTH)+1.

Reset
REQ-033 SHALL, while RST=0, immediately force FSM=IDLE, entry count=0, pointers=0, mem_req=0, mem_we=0, Stall=0, ReadData=0 and sb_empty=1.
REQ-034 SHALL discard buffered stores and any in-flight request when reset is asserted mid-operation; a late mem_ack after reset is ignored.

Configuration
REQ-035 SHALL support macro DATA_MEM_CTRL_FWD_EN; when defined, store-to-load forwarding follows REQ-022.
REQ-036 SHALL, when DATA_MEM_CTRL_FWD_EN is undefined, omit the match logic and stall every load with Stall=1 until the buffer is empty, then take the LOAD path.

Structure
REQ-037 SHALL place the FSM state enum (IDLE/DRAIN/LOAD/LDONE) and the SB_DEPTH default in shared package data_mem_pkg.
REQ-038 SHALL implement the buffer storage, pointers, count and match search as sub-module store_fifo.

Verification
REQ-039 SHALL cover: store 0xDEADBEEF to 0x40 with mem_ack tied high -> Stall=0; next cycle mem_req=1, mem_we=1, mem_addr=0x40; sb_empty=1 after the ack.
REQ-040 SHALL cover: 5 back-to-back stores with mem_ack held low -> Stall=1 on the 5th store; after one ack the 5th store is accepted.
REQ-041 SHALL cover: store 0x11 then 0x22 to 0x80, then load 0x80 with acks held low -> ReadData=0x22 with Stall=0 in the same cycle (FWD_EN defined).
REQ-042 SHALL cover: load miss to 0x100 with mem_rdata=0xCAFE0001 and ack 3 cycles after the request -> Stall=1 for 4 cycles, then LDONE with ReadData=0xCAFE0001.
REQ-043 SHALL cover: RST driven low during a DRAIN with 3 entries buffered -> mem_req=0 immediately, sb_empty=1, no write issued after release.
REQ-044 SHALL cover: FWD_EN undefined, 2 buffered stores, load 0x80 -> 2 writes complete before the read request is issued.
